alu_mul_sequencer: RTL and testbench
====================================

# alu_mul_sequencer

Multi-cycle sequencer that computes the low 32 bits of a 32×32 product (RISC-V MUL semantics) using the core's shared 32-bit ALU. It performs shift-and-add, one multiplier bit per step, and stops early once the remaining multiplier bits are zero. It sits beside the datapath ALU and drives that ALU's operation-select and operand inputs while a multiply is in flight. Around it, a start/busy/done interface serves the control unit.

## Interface
- DATA_WIDTH, 32, operand/result width; fixed at 32 in this core.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; returns the block to IDLE.
- start_i  in  1  request pulse; sampled only in IDLE.
- multiplicand_i  in  32  operand A; captured on the accepted start edge.
- multiplier_i  in  32  operand B; captured on the accepted start edge.
- busy_o  out  1  high whenever state ≠ IDLE.
- done_o  out  1  one-cycle pulse; high only in the DONE state.
- product_o  out  32  registered low word of the product; holds until the next DONE or reset.
- ALU_Operation_o  out  4  ALU op select: ADD = 4'b0000, SLLI = 4'b0011.
- ALU_A_o  out  32  ALU operand A.
- ALU_B_o  out  32  ALU operand B.
- ALU_Result_i  in  32  combinational ALU result, consumed in the same cycle.

## Operation
- Internal registers:
  - acc: accumulator.
  - mcand: shifted multiplicand.
  - mplier: remaining multiplier bits.
  - state ∈ {IDLE, EVAL, ADD, SHIFT, DONE}.
- IDLE:
  - On start_i = 1, load acc = 0, mcand = multiplicand_i, mplier = multiplier_i, and go to EVAL.
  - Otherwise stay in IDLE.
- EVAL (no ALU use):
  - If mplier == 0, copy acc into product_o and go to DONE.
  - Else if mplier[0] == 1, go to ADD.
  - Else go to SHIFT.
- ADD:
  - Drive ALU_Operation_o = ADD, ALU_A_o = acc, ALU_B_o = mcand.
  - At the edge, acc ← ALU_Result_i. Go to SHIFT.
- SHIFT:
  - Drive ALU_Operation_o = SLLI, ALU_A_o = mcand, ALU_B_o = 1.
  - At the edge, mcand ← ALU_Result_i and mplier ← mplier >> 1 (logical, internal). Go to EVAL.
- DONE: done_o = 1. Next state is IDLE unconditionally.
- ALU outputs in IDLE, EVAL and DONE: ALU_Operation_o = 4'b0000, ALU_A_o = 0, ALU_B_o = 0.
- Arithmetic:
  - All adds wrap modulo 2^32. The result is the low word only.
  - Signed and unsigned operands give identical bits; no sign handling is performed.
- Termination is guaranteed: a logical right shift empties mplier after at most 32 SHIFT steps.
- start_i outside IDLE (including the DONE cycle) is ignored. The operand inputs are don't-care outside the accept edge.

## Timing
- Reset values (reset asserted at an edge, effective the next cycle):
  - state = IDLE; busy_o = 0; done_o = 0; product_o = 0.
  - acc, mcand, mplier = 0; ALU outputs as for IDLE.
- Reset has priority over start_i.
- Reset mid-operation aborts the multiply: no done_o pulse, and product_o is cleared to 0.
- Latency, with the start accepted at edge 0:
  - done_o is high in cycle 2 + 2k + p.
  - k = (index of the highest set multiplier bit) + 1, with k = 0 when the multiplier is 0.
  - p = popcount(multiplier).
  - Minimum is 2 cycles (multiplier = 0); maximum is 98 cycles (multiplier = 0xFFFFFFFF).
- busy_o rises in cycle 1 and falls in the cycle after DONE.
- The earliest next start is accepted at the edge ending the DONE cycle + 1, i.e. in IDLE.
- product_o changes only on the EVAL→DONE edge. It is therefore already valid in the cycle done_o is high.
- The ALU path is combinational within one cycle: outputs are driven from registers, and ALU_Result_i is captured at the same edge.

## Test plan
- Reset, then start with 7 × 6 → done_o in cycle 10, product_o = 0x0000002A, busy_o high in cycles 1–10, low in cycle 11.
- 0x00001234 × 0 → done_o in cycle 2, product_o = 0, no ADD or SLLI op ever driven.
- 0xFFFFFFFD (−3) × 5 → done_o in cycle 10, product_o = 0xFFFFFFF1; 0xFFFFFFFF × 0xFFFFFFFF → done_o in cycle 98, product_o = 0x00000001.
- ALU trace for 9 × 1:
  - Cycle 2: ALU_Operation_o = 0000, ALU_A_o = 0, ALU_B_o = 9.
  - Cycle 3: ALU_Operation_o = 0011, ALU_A_o = 9, ALU_B_o = 1.
  - Cycle 4: EVAL with zeros driven.
  - Cycle 5: done_o = 1, product_o = 9.
- start_i held high for the whole 7 × 6 run, with the operands changed mid-run → product_o stays 42. A new start is accepted only in the IDLE cycle after DONE.
- reset asserted in cycle 4 of 7 × 6 after a prior result of 9 → from cycle 5 busy_o = 0 and product_o = 0, with no done_o pulse. A following 3 × 3 start returns 9 in cycle 8.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: shift-and-add 32x32 low-word multiply driven through the shared datapath ALU
module alu_mul_sequencer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [DATA_WIDTH-1:0] multiplicand_i,
   input  logic [DATA_WIDTH-1:0] multiplier_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] product_o,
   output logic [3:0]            ALU_Operation_o,
   output logic [DATA_WIDTH-1:0] ALU_A_o,
   output logic [DATA_WIDTH-1:0] ALU_B_o,
   input  logic [DATA_WIDTH-1:0] ALU_Result_i
);
   typedef enum logic [2:0] {IDLE, EVAL, ADD, SHIFT, DONE} state_t;
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SLLI = 4'b0011;
   state_t state;
   logic [DATA_WIDTH-1:0] acc, mcand, mplier;
   // ALU drive is registered for the state being entered, so it lines up with that state's cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         acc             <= '0;
         mcand           <= '0;
         mplier          <= '0;
         product_o       <= '0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         ALU_Operation_o <= OP_ADD;
         ALU_A_o         <= '0;
         ALU_B_o         <= '0;
      end else begin
         done_o          <= 1'b0;
         ALU_Operation_o <= OP_ADD;
         ALU_A_o         <= '0;
         ALU_B_o         <= '0;
         case (state)
            IDLE: if (start_i) begin
               acc    <= '0;
               mcand  <= multiplicand_i;
               mplier <= multiplier_i;
               busy_o <= 1'b1;
               state  <= EVAL;
            end
            EVAL: if (mplier == '0) begin
               product_o <= acc;
               done_o    <= 1'b1;
               state     <= DONE;
            end else if (mplier[0]) begin
               ALU_A_o <= acc;
               ALU_B_o <= mcand;
               state   <= ADD;
            end else begin
               ALU_Operation_o <= OP_SLLI;
               ALU_A_o         <= mcand;
               ALU_B_o         <= DATA_WIDTH'(1);
               state           <= SHIFT;
            end
            ADD: begin
               acc             <= ALU_Result_i;
               ALU_Operation_o <= OP_SLLI;
               ALU_A_o         <= mcand;
               ALU_B_o         <= DATA_WIDTH'(1);
               state           <= SHIFT;
            end
            SHIFT: begin
               mcand  <= ALU_Result_i;
               mplier <= mplier >> 1;
               state  <= EVAL;
            end
            DONE: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: directed checks of the multiply sequencer against a behavioural ALU
module tb_alu_mul_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] mcand_in = '0, mplier_in = '0;
   logic        busy, done;
   logic [31:0] product, alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;
   int checks = 0, errors = 0;
   int alu_active = 0, done_count = 0;
   always #5 clk = ~clk;
   alu_mul_sequencer #(.DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start_i(start),
      .multiplicand_i(mcand_in), .multiplier_i(mplier_in),
      .busy_o(busy), .done_o(done), .product_o(product),
      .ALU_Operation_o(alu_op), .ALU_A_o(alu_a), .ALU_B_o(alu_b),
      .ALU_Result_i(alu_result)
   );
   // Reference ALU: ADD and SLLI only
   always_comb alu_result = (alu_op == 4'b0000) ? alu_a + alu_b :
                            (alu_op == 4'b0011) ? alu_a << alu_b[4:0] : 32'h0;
   always @(posedge clk) begin
      if (alu_op != 4'b0000 || alu_a != 0 || alu_b != 0) alu_active++;
      if (done) done_count++;
   end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_p, input int exp_cyc);
      int cyc, busy_bad;
      mcand_in = a; mplier_in = b; start = 1'b1;
      tick;
      start = 1'b0;
      cyc = 1; busy_bad = 0;
      while (!done && cyc < 200) begin
         if (!busy) busy_bad++;
         tick;
         cyc++;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
      chk({tag, "_product"}, product, exp_p);
      chk({tag, "_busy_during"}, 32'(busy_bad), 32'd0);
      tick;
      chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
   endtask
   initial begin
      int base, cyc;
      tick; tick;
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_product", product, 32'd0);
      chk("rst_alu", {alu_op, alu_a[27:0]} | alu_b, 32'd0);
      run("mul_7x6", 32'd7, 32'd6, 32'h2A, 10);
      base = alu_active;
      run("mul_by_zero", 32'h1234, 32'd0, 32'd0, 2);
      chk("zero_no_alu", 32'(alu_active - base), 32'd0);
      run("mul_neg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 10);
      run("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 98);
      // ALU trace for 9 x 1
      mcand_in = 32'd9; mplier_in = 32'd1; start = 1'b1;
      tick; start = 1'b0;
      tick;
      chk("tr_c2_op", {28'd0, alu_op}, 32'h0);
      chk("tr_c2_a", alu_a, 32'd0);
      chk("tr_c2_b", alu_b, 32'd9);
      tick;
      chk("tr_c3_op", {28'd0, alu_op}, 32'h3);
      chk("tr_c3_a", alu_a, 32'd9);
      chk("tr_c3_b", alu_b, 32'd1);
      tick;
      chk("tr_c4_zero", {28'd0, alu_op} | alu_a | alu_b, 32'd0);
      chk("tr_c4_done", {31'd0, done}, 32'd0);
      tick;
      chk("tr_c5_done", {31'd0, done}, 32'd1);
      chk("tr_c5_product", product, 32'd9);
      tick;
      // start held high through a 7 x 6 run while the operands wander
      mcand_in = 32'd7; mplier_in = 32'd6; start = 1'b1;
      tick;
      for (int i = 2; i <= 10; i++) begin
         mcand_in = $urandom; mplier_in = $urandom;
         tick;
      end
      chk("hold_done_c10", {31'd0, done}, 32'd1);
      chk("hold_product", product, 32'h2A);
      mcand_in = 32'd3; mplier_in = 32'd3;
      tick;
      chk("hold_idle_c11", {31'd0, busy}, 32'd0);
      tick;
      chk("hold_restart_busy", {31'd0, busy}, 32'd1);
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 200) begin tick; cyc++; end
      chk("restart_latency", 32'(cyc), 32'd8);
      chk("restart_product", product, 32'd9);
      tick;
      // reset in cycle 4 aborts a 7 x 6 run after a prior result of 9
      base = done_count;
      mcand_in = 32'd7; mplier_in = 32'd6; start = 1'b1;
      tick; start = 1'b0;
      tick; tick; tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_product", product, 32'd0);
      for (int i = 0; i < 12; i++) tick;
      chk("abort_no_done", 32'(done_count - base), 32'd0);
      run("after_abort_3x3", 32'd3, 32'd3, 32'd9, 8);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
